uart_rx_byte: RTL

- UART receiver: 8N1 frames, LSB first, idle-high line. Default 9600 baud from 50 MHz.
- Counterpart of the transmit path. Uses the same bit-period convention: count from 0 to BAUD_COUNT, so one bit lasts BAUD_COUNT+1 cycles.
- Recovers each byte by sampling at mid-bit.
- Presents the byte with a one-cycle valid strobe, and flags bad stop bits.

---
 rtl/uart_rx_byte.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte -- 8N1 UART receiver, LSB first, idle-high line.
//
// The line is double-synchronised; a falling edge on the synchronised line
// starts a frame. The start bit is re-checked at mid-bit to reject glitches,
// then each data bit and the stop bit are sampled one bit period apart, so
// every sample lands at mid-bit. A bit lasts BAUD_COUNT+1 clocks.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   rx_in      asynchronous serial line, idle high
//   rx_data    last correctly received byte, held until the next good frame
//   rx_valid   one-cycle pulse, rx_data is new this cycle
//   frame_err  one-cycle pulse, the stop bit sampled low
//   busy       high while a frame is being received (state is not IDLE)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a falling edge on the synchronised line
// START | timing to start-bit mid-point; line must still be low
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit; good frame -> rx_valid, else frame_err

module uart_rx_byte #(
  parameter int CNT_W      = 13,
  parameter int BAUD_COUNT = 5207,
  parameter int HALF_COUNT = 2603
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] BAUD_C = CNT_W'(BAUD_COUNT);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF_COUNT);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift_q, shift_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt, ferr_nxt;

  // rx_m/rx_s form the synchroniser; rx_p is the previous rx_s for edge detect.
  // All three reset high so a reset never looks like a start edge.
  logic rx_m, rx_s, rx_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift_q   <= shift_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_q;
    data_nxt    = rx_data;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // Edge only: a line held low (break) never retriggers.
        if (!rx_s && rx_p) state_nxt = START;
      end

      START: begin
        if (cnt == HALF_C) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_1;
        end
      end

      DATA: begin
        if (cnt == BAUD_C) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s, shift_q[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt + CNT_1;
        end
      end

      STOP: begin
        if (cnt == BAUD_C) begin
          cnt_nxt   = '0;
          // Returning to IDLE at stop mid-bit leaves half a bit to catch
          // the next start edge of a back-to-back frame.
          state_nxt = IDLE;
          if (rx_s) begin
            data_nxt  = shift_q;
            valid_nxt = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
